// File: rtl/cpu_pkg.sv
// Shared definitions for the SAP-style CPU: default bus/address widths and
// the RAM loader state encoding.
package cpu_pkg;

  localparam int CPU_DATA_W = 8;
  localparam int CPU_ADDR_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } ld_state_e;

endpackage

// File: rtl/bus_transceiver.sv
// Tri-state bus driver: presents a onto the shared bus b while oe_n is low,
// releases the bus (high-Z) otherwise.
module bus_transceiver #(
  parameter int W = 8
) (
  input  logic         oe_n,
  input  logic [W-1:0] a,
  inout  wire  [W-1:0] b
);

  assign b = oe_n ? {W{1'bz}} : a;

endmodule

// File: rtl/mar_ram_loader.sv
// Byte-stream loader that fills the program RAM from the chip pins.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for prog_mode; no writes
// LOAD  | accepting one byte per valid cycle into ram[ptr]
// DONE  | all words written; waits for prog_mode to drop
module mar_ram_loader
  import cpu_pkg::*;
#(
  parameter int DATA_W = CPU_DATA_W,
  parameter int ADDR_W = CPU_ADDR_W
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic              prog_mode,
  input  logic              prog_valid,
  input  logic [DATA_W-1:0] prog_data,
  output logic              prog_ready,
  output logic              prog_done,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data
);

  localparam logic [ADDR_W-1:0] LAST = {ADDR_W{1'b1}};

  ld_state_e         state, state_nx;
  logic [ADDR_W-1:0] ptr, ptr_nx;

  // State and pointer registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      state <= IDLE;
      ptr   <= '0;
    end else begin
      state <= state_nx;
      ptr   <= ptr_nx;
    end
  end

  // Next-state and pointer advance; the pointer stops at the last word.
  always_comb begin
    state_nx = state;
    ptr_nx   = ptr;
    unique case (state)
      IDLE: begin
        if (prog_mode) begin
          state_nx = LOAD;
          ptr_nx   = '0;
        end
      end
      LOAD: begin
        if (!prog_mode) begin
          state_nx = IDLE;
        end else if (prog_valid) begin
          if (ptr == LAST) state_nx = DONE;
          else             ptr_nx   = ptr + 1'b1;
        end
      end
      DONE: begin
        if (!prog_mode) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Handshake and write strobe; dropping prog_mode in LOAD stops writes at once.
  always_comb begin
    prog_ready = 1'b0;
    prog_done  = 1'b0;
    wr_en      = 1'b0;
    unique case (state)
      LOAD: begin
        prog_ready = prog_mode;
        wr_en      = prog_mode & prog_valid;
      end
      DONE:    prog_done = 1'b1;
      default: ;
    endcase
  end

  assign wr_addr = ptr;
  assign wr_data = prog_data;

endmodule

// File: rtl/mar_ram.sv
// Memory address register plus 16-word program/data RAM on the shared CPU bus.
// Optional: define MAR_RAM_CLR_EN to zero all RAM words during reset;
// without it the array has no reset and keeps its contents.
module mar_ram
  import cpu_pkg::*;
#(
  parameter int DATA_W = CPU_DATA_W,
  parameter int ADDR_W = CPU_ADDR_W
) (
  input  logic              clk,
  input  logic              clr_n,
  inout  wire  [DATA_W-1:0] bus,
  input  logic              mi_n,
  input  logic              ri,
  input  logic              ro_n,
  input  logic              prog_mode,
  input  logic              prog_valid,
  input  logic [DATA_W-1:0] prog_data,
  output logic              prog_ready,
  output logic              prog_done,
  output logic [ADDR_W-1:0] mar_q
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [ADDR_W-1:0] mar;
  logic [DATA_W-1:0] ram [DEPTH];
  logic              ld_we;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_data;
  logic              cpu_we;
  logic              mar_ld;
  logic [DATA_W-1:0] rd_data;

  assign cpu_we = ~prog_mode & ri;
  assign mar_ld = ~prog_mode & ~mi_n;

  mar_ram_loader #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_loader (
    .clk        (clk),
    .clr_n      (clr_n),
    .prog_mode  (prog_mode),
    .prog_valid (prog_valid),
    .prog_data  (prog_data),
    .prog_ready (prog_ready),
    .prog_done  (prog_done),
    .wr_en      (ld_we),
    .wr_addr    (ld_addr),
    .wr_data    (ld_data)
  );

  // MAR captures the low bus bits; upper bits are don't-care.
  always_ff @(posedge clk) begin
    if (!clr_n)      mar <= '0;
    else if (mar_ld) mar <= bus[ADDR_W-1:0];
  end

  // RAM write port; loader and CPU writes are exclusive through prog_mode.
  // A CPU write uses the pre-edge MAR even if MAR loads in the same cycle.
  always_ff @(posedge clk) begin
`ifdef MAR_RAM_CLR_EN
    if (!clr_n) begin
      for (int i = 0; i < DEPTH; i++) ram[i] <= '0;
    end else if (ld_we) begin
      ram[ld_addr] <= ld_data;
    end else if (cpu_we) begin
      ram[mar] <= bus;
    end
`else
    if (clr_n) begin
      if (ld_we)       ram[ld_addr] <= ld_data;
      else if (cpu_we) ram[mar]     <= bus;
    end
`endif
  end

  assign rd_data = ram[mar];
  assign mar_q   = mar;

  bus_transceiver #(
    .W (DATA_W)
  ) u_xcvr (
    .oe_n (ro_n | prog_mode),
    .a    (rd_data),
    .b    (bus)
  );

endmodule

// File: tb/tb_mar_ram.sv
// Directed bench for mar_ram: reset, loader stream, bus read/write, indirect
// MAR load, loader abort and reset mid-load, optional RAM clear.
module tb_mar_ram;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;

  logic              clk = 1'b0;
  logic              clr_n;
  wire  [DATA_W-1:0] bus;
  logic              mi_n, ri, ro_n;
  logic              prog_mode, prog_valid;
  logic [DATA_W-1:0] prog_data;
  logic              prog_ready, prog_done;
  logic [ADDR_W-1:0] mar_q;

  logic [DATA_W-1:0] drv;
  logic              drv_en;

  int n_chk  = 0;
  int n_pass = 0;

  // Released bus floats to all-ones through the pullup.
  assign bus = drv_en ? drv : {DATA_W{1'bz}};
  pullup pu_bus (bus);

  always #5 clk = ~clk;

  mar_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .clr_n      (clr_n),
    .bus        (bus),
    .mi_n       (mi_n),
    .ri         (ri),
    .ro_n       (ro_n),
    .prog_mode  (prog_mode),
    .prog_valid (prog_valid),
    .prog_data  (prog_data),
    .prog_ready (prog_ready),
    .prog_done  (prog_done),
    .mar_q      (mar_q)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else             n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_mar(input logic [DATA_W-1:0] v);
    drv_en = 1'b1;
    drv    = v;
    mi_n   = 1'b0;
    tick();
    mi_n   = 1'b1;
    drv_en = 1'b0;
  endtask

  task automatic read_at(input logic [ADDR_W-1:0] a, output logic [DATA_W-1:0] v);
    set_mar({4'h0, a});
    ro_n = 1'b0;
    #1;
    v    = bus;
    ro_n = 1'b1;
    #1;
  endtask

  task automatic stream(input logic [DATA_W-1:0] base, input int n, input bool_const);
    for (int i = 0; i < n; i++) begin
      prog_valid = 1'b1;
      prog_data  = bool_const ? base : base + DATA_W'(i);
      tick();
    end
    prog_valid = 1'b0;
  endtask

  logic [DATA_W-1:0] rd;
  logic [DATA_W-1:0] shadow [16];
  int                accepts;

  initial begin
    clr_n = 1'b0; mi_n = 1'b1; ri = 1'b0; ro_n = 1'b1;
    prog_mode = 1'b0; prog_valid = 1'b0; prog_data = '0;
    drv = '0; drv_en = 1'b0;
    tick();
    clr_n = 1'b1;

    // Reset with MAR previously at 7
    set_mar(8'h07);
    check("mar_pre_reset", mar_q, 4'h7);
    clr_n = 1'b0;
    tick();
    clr_n = 1'b1;
    check("rst_mar", mar_q, 4'h0);
    check("rst_ready", prog_ready, 1'b0);
    check("rst_done", prog_done, 1'b0);
    check("rst_bus_z", bus, 8'hFF);

    // Full load 0x10..0x1F with valid held
    prog_mode = 1'b1;
    tick();
    accepts = 0;
    for (int i = 0; i < 16; i++) begin
      prog_valid = 1'b1;
      prog_data  = 8'h10 + 8'(i);
      if (prog_ready) accepts++;
      tick();
      shadow[i] = 8'h10 + 8'(i);
    end
    check("ld_accepts", accepts, 16);
    check("ld_done", prog_done, 1'b1);
    check("ld_ready_off", prog_ready, 1'b0);
    prog_data = 8'hEE;
    tick();
    prog_valid = 1'b0;
    check("ld_done_hold", prog_done, 1'b1);
    prog_mode = 1'b0;
    tick();
    check("ld_idle_done", prog_done, 1'b0);

    // Bus read after load
    set_mar(8'h05);
    check("rd_mar", mar_q, 4'h5);
    ro_n = 1'b0; #1;
    check("rd_bus5", bus, 8'h15);
    ro_n = 1'b1; #1;
    check("rd_bus_z", bus, 8'hFF);
    read_at(4'hF, rd);
    check("rd_17th_ignored", rd, 8'h1F);
    read_at(4'h0, rd);
    check("rd_addr0", rd, 8'h10);

    // Upper bus bits ignored by MAR
    set_mar(8'hE9);
    check("mar_upper_ignored", mar_q, 4'h9);

    // Write with simultaneous MAR load
    set_mar(8'h05);
    drv = 8'hA3; drv_en = 1'b1; ri = 1'b1; mi_n = 1'b0;
    tick();
    ri = 1'b0; mi_n = 1'b1; drv_en = 1'b0;
    shadow[5] = 8'hA3;
    check("wr_mar", mar_q, 4'h3);
    ro_n = 1'b0; #1;
    check("wr_rd3", bus, 8'h13);
    ro_n = 1'b1; #1;
    read_at(4'h5, rd);
    check("wr_rd5", rd, 8'hA3);

    // CPU controls ignored in prog_mode
    prog_mode = 1'b1;
    drv = 8'h09; drv_en = 1'b1; mi_n = 1'b0; ri = 1'b1;
    tick();
    check("pm_mar_hold", mar_q, 4'h5);
    mi_n = 1'b1; ri = 1'b0; drv_en = 1'b0; ro_n = 1'b0; #1;
    check("pm_bus_z", bus, 8'hFF);
    ro_n = 1'b1;
    prog_mode = 1'b0;
    tick();
    read_at(4'h5, rd);
    check("pm_no_write", rd, 8'hA3);

    // Indirect addressing: MAR loads from RAM data (0xA3 -> 3)
    ro_n = 1'b0; mi_n = 1'b0;
    tick();
    ro_n = 1'b1; mi_n = 1'b1;
    check("indirect_mar", mar_q, 4'h3);

    // Abort mid-load after 4 bytes
    prog_mode = 1'b1;
    tick();
    stream(8'h40, 4, 1'b0);
    for (int i = 0; i < 4; i++) shadow[i] = 8'h40 + 8'(i);
    prog_mode = 1'b0;
    prog_valid = 1'b1; prog_data = 8'h77;
    tick();
    check("abort_ready", prog_ready, 1'b0);
    check("abort_done", prog_done, 1'b0);
    tick();
    prog_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      read_at(4'(i), rd);
      check($sformatf("abort_ram%0d", i), rd, shadow[i]);
    end

    // Reset mid-load after 4 bytes
    prog_mode = 1'b1;
    tick();
    stream(8'h50, 4, 1'b0);
    for (int i = 0; i < 4; i++) shadow[i] = 8'h50 + 8'(i);
    clr_n = 1'b0;
    tick();
    clr_n = 1'b1; prog_mode = 1'b0;
    check("rstld_ready", prog_ready, 1'b0);
    tick();
    check("rstld_idle", prog_ready, 1'b0);
    for (int i = 0; i < 16; i++) begin
      read_at(4'(i), rd);
`ifdef MAR_RAM_CLR_EN
      check($sformatf("rstld_ram%0d", i), rd, 8'h00);
`else
      check($sformatf("rstld_ram%0d", i), rd, shadow[i]);
`endif
    end

    // Fill with 0xFF, then reset: cleared only when the clear option is built in
    prog_mode = 1'b1;
    tick();
    stream(8'hFF, 16, 1'b1);
    check("ff_done", prog_done, 1'b1);
    prog_mode = 1'b0;
    tick();
    clr_n = 1'b0;
    tick();
    clr_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      read_at(4'(i), rd);
`ifdef MAR_RAM_CLR_EN
      check($sformatf("clr_ram%0d", i), rd, 8'h00);
`else
      check($sformatf("clr_ram%0d", i), rd, 8'hFF);
`endif
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mar_ram.md
Name: mar_ram

Overview:
- Bus-reading end of the program-counter path: memory address register (MAR) plus 16-word program/data RAM for the 8-bit SAP-style CPU.
- MAR captures the instruction index the program counter drives onto the shared bus (co_n low), selects a RAM word, and RAM drives or accepts bus data under control-word signals.
- Includes a byte-stream loader FSM that fills RAM from the chip pins before the CPU runs.

Parameters:
- DATA_W, 8, bus and RAM word width.
- ADDR_W, 4, MAR width. DEPTH = 2**ADDR_W (16) is a derived localparam, not overridable.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- clr_n  input  1  reset, synchronous, active-low.
- bus  inout  DATA_W  shared CPU bus; MAR reads bus[ADDR_W-1:0].
- mi_n  input  1  MAR in, active-low.
- ri  input  1  RAM in (write from bus), active-high.
- ro_n  input  1  RAM out to bus, active-low.
- prog_mode  input  1  1 = loader owns RAM; CPU-side controls ignored.
- prog_valid  input  1  loader byte valid.
- prog_data  input  DATA_W  loader byte.
- prog_ready  output  1  loader accepts byte this cycle.
- prog_done  output  1  all DEPTH words loaded.
- mar_q  output  ADDR_W  current MAR value (to display/debug).

Behaviour:
- Reset (clr_n=0 at edge): mar_q=0, loader state IDLE, load pointer=0, prog_ready=0, prog_done=0; bus released (high-Z) from that point. RAM contents untouched (see optional feature).
- MAR: when prog_mode=0 and mi_n=0, mar <= bus[ADDR_W-1:0] at the edge; upper bus bits are ignored.
- Write: when prog_mode=0 and ri=1, ram[mar] <= bus at the edge. With mi_n=0 and ri=1 in the same cycle, the write uses the pre-edge MAR value; MAR updates simultaneously.
- Read: when prog_mode=0 and ro_n=0, bus = ram[mar] combinationally (zero-cycle latency after the MAR/RAM edge); otherwise bus is high-Z. Drive goes through the existing bus_transceiver instance, with OE_n tied to (ro_n | prog_mode).
- ro_n=0 with ri=1: word rewritten with its own value; no change. ro_n=0 with mi_n=0: MAR loads bus[3:0] of the RAM data (indirect addressing); this is legal.
- Loader FSM states IDLE, LOAD, DONE:
  - IDLE: prog_ready=0, prog_done=0. prog_mode=1 -> LOAD with ptr=0.
  - LOAD: prog_ready=1. prog_valid & prog_ready -> ram[ptr] <= prog_data, ptr <= ptr+1. Accepting at ptr=DEPTH-1 -> DONE (no wrap; ptr held).
  - DONE: prog_ready=0, prog_done=1. prog_mode=0 -> IDLE.
  - prog_mode=0 in LOAD -> IDLE next cycle; already-written words are kept, no further writes occur.
- While prog_mode=1: mi_n, ri, ro_n are ignored, MAR holds, bus is high-Z.
- Reset mid-load: FSM returns to IDLE; the partially written RAM is kept.
- prog_valid while not in LOAD: ignored.

Optional Feature:
- Macro: MAR_RAM_CLR_EN.
- Defined: a synchronous reset additionally zeroes all DEPTH RAM words in the reset cycle.
- Undefined: reset leaves RAM contents unchanged (RAM maps to plain storage with no reset net).

Decomposition:
- Shared package cpu_pkg holds DATA_W/ADDR_W defaults and the loader state encoding (IDLE=2'd0, LOAD=2'd1, DONE=2'd2).
- One sub-module, mar_ram_loader: the FSM plus pointer, outputting the write enable, address, and data into the RAM array.
- MAR, array, and bus drive stay in mar_ram.

Test Plan:
- Reset: clr_n=0 for 1 edge with prior mar=7 -> mar_q=0, prog_ready=0, prog_done=0, bus high-Z.
- Loader: prog_mode=1, stream bytes 0x10..0x1F with prog_valid held -> 16 accepts over 16 cycles, prog_done=1 on the cycle after the last accept, prog_ready=0. A 17th valid byte is not written.
- Bus read: after load, prog_mode=0, drive bus=0x05 with mi_n=0 -> mar_q=5; ro_n=0 -> bus reads 0x15 the same cycle; ro_n=1 -> bus high-Z.
- Write with simultaneous MAR load: mar=5, bus=0xA3, ri=1, mi_n=0 -> ram[5]=0xA3, mar_q=3; then ro_n=0 -> bus=0x13.
- Abort and reset mid-load: 4 bytes accepted, then prog_mode=0 -> IDLE, words 0..3 hold new data and 4..15 hold old data. Repeat with clr_n=0 mid-load -> same outcome.
- MAR_RAM_CLR_EN defined: load 0xFF everywhere, pulse clr_n -> every address reads 0x00. Macro undefined -> addresses still read 0xFF.
